// File: rtl/clic_seq_pkg.sv
// Shared types for the CLIC interrupt sequencer: FSM state encoding and the
// RISC-V privilege encoding used on the offered-interrupt priv field.
package clic_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER,
    KILL
  } clic_state_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

endpackage

// File: rtl/clic_max_tree.sv
// Combinational max-level comparator tree over NumIrq sources; ties resolve
// to the lower index at every node so the overall winner is the lowest id.
module clic_max_tree #(
  parameter int unsigned NumIrq     = 64,
  parameter int unsigned IdWidth    = $clog2(NumIrq),
  parameter int unsigned LevelWidth = 8
) (
  input  logic [NumIrq-1:0]                 elig_i,
  input  logic [NumIrq-1:0][LevelWidth-1:0] level_i,
  output logic                              win_valid_o,
  output logic [IdWidth-1:0]                win_id_o,
  output logic [LevelWidth-1:0]             win_level_o
);

  localparam int unsigned Leaves = 1 << IdWidth;

  // One signal set per stage keeps the tree acyclic at the variable level.
  for (genvar s = 0; s <= IdWidth; s++) begin : g_stage
    localparam int unsigned W = Leaves >> s;
    logic [W-1:0]                 vld;
    logic [W-1:0][LevelWidth-1:0] lvl;
    logic [W-1:0][IdWidth-1:0]    id;

    if (s == 0) begin : g_leaf
      for (genvar l = 0; l < Leaves; l++) begin : g_src
        if (l < NumIrq) begin : g_real
          assign vld[l] = elig_i[l];
          assign lvl[l] = elig_i[l] ? level_i[l] : '0;
          assign id[l]  = IdWidth'(l);
        end else begin : g_pad
          assign vld[l] = 1'b0;
          assign lvl[l] = '0;
          assign id[l]  = IdWidth'(l);
        end
      end
    end else begin : g_merge
      for (genvar n = 0; n < W; n++) begin : g_node
        logic take_hi;
        assign take_hi = g_stage[s-1].vld[2*n+1] &
                         (~g_stage[s-1].vld[2*n] |
                          (g_stage[s-1].lvl[2*n+1] > g_stage[s-1].lvl[2*n]));
        assign vld[n] = g_stage[s-1].vld[2*n] | g_stage[s-1].vld[2*n+1];
        assign lvl[n] = take_hi ? g_stage[s-1].lvl[2*n+1] : g_stage[s-1].lvl[2*n];
        assign id[n]  = take_hi ? g_stage[s-1].id[2*n+1]  : g_stage[s-1].id[2*n];
      end
    end
  end

  assign win_valid_o = g_stage[IdWidth].vld[0];
  assign win_level_o = g_stage[IdWidth].lvl[0];
  assign win_id_o    = g_stage[IdWidth].id[0];

endmodule

// File: rtl/clic_irq_sequencer.sv
// CLIC interrupt sequencer: arbitrates level-sensitive sources, offers the
// winner to the core with a stable registered offer, and retracts stale offers.
module clic_irq_sequencer
  import clic_seq_pkg::*;
#(
  parameter int unsigned NumIrq     = 64,
  parameter int unsigned IdWidth    = $clog2(NumIrq),
  parameter int unsigned LevelWidth = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic [LevelWidth-1:0]             threshold_i,
  input  logic [NumIrq-1:0]                 irq_pending_i,
  input  logic [NumIrq-1:0][LevelWidth-1:0] irq_level_i,
  input  logic [NumIrq-1:0][1:0]            irq_priv_i,
  input  logic [NumIrq-1:0]                 irq_shv_i,
  output logic                              clic_irq_valid_o,
  output logic [IdWidth-1:0]                clic_irq_id_o,
  output logic [LevelWidth-1:0]             clic_irq_level_o,
  output logic [1:0]                        clic_irq_priv_o,
  output logic                              clic_irq_shv_o,
  input  logic                              clic_irq_ready_i,
  output logic                              clic_kill_req_o,
  input  logic                              clic_kill_ack_i,
  output logic                              claim_valid_o,
  output logic [IdWidth-1:0]                claim_id_o
);

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [LevelWidth-1:0] level;
    logic [1:0]            priv;
    logic                  shv;
  } clic_offer_t;

  clic_state_e state_q, state_d;
  clic_offer_t offer_q, offer_d;
  logic        claim_valid_q, claim_valid_d;

  logic [NumIrq-1:0]     elig;
  logic [NumIrq-1:0]     offer_onehot;
  logic [NumIrq-1:0]     arb_mask;
  logic                  win_valid;
  logic [IdWidth-1:0]    win_id;
  logic [LevelWidth-1:0] win_level;
  logic                  offered_elig;
  logic                  preempt;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NumIrq; i++) begin
      elig[i] = irq_pending_i[i] & (irq_level_i[i] != '0) & (irq_level_i[i] > threshold_i);
    end
  end

  // While an offer is live the offered source is masked out, so the tree
  // reports the strongest *other* contender for the preemption check.
  always_comb begin
    offer_onehot = '0;
    if (state_q == OFFER) begin
      offer_onehot[offer_q.id] = 1'b1;
    end
  end

  assign arb_mask = elig & ~offer_onehot;

  clic_max_tree #(
    .NumIrq    (NumIrq),
    .IdWidth   (IdWidth),
    .LevelWidth(LevelWidth)
  ) u_max_tree (
    .elig_i     (arb_mask),
    .level_i    (irq_level_i),
    .win_valid_o(win_valid),
    .win_id_o   (win_id),
    .win_level_o(win_level)
  );

  assign offered_elig = elig[offer_q.id];
  assign preempt      = win_valid & (win_level > offer_q.level);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      offer_q       <= '0;
      claim_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      offer_q       <= offer_d;
      claim_valid_q <= claim_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i && win_valid) state_d = SELECT;
      end
      SELECT: begin
        state_d = (enable_i && win_valid) ? OFFER : IDLE;
      end
      OFFER: begin
        if (clic_irq_ready_i) begin
          state_d = IDLE;
        end else if (!enable_i || !offered_elig || preempt) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (clic_kill_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    offer_d = offer_q;
    if (state_q == SELECT && enable_i && win_valid) begin
      offer_d.id    = win_id;
      offer_d.level = win_level;
      offer_d.priv  = irq_priv_i[win_id];
      offer_d.shv   = irq_shv_i[win_id];
    end
    claim_valid_d = (state_q == OFFER) & clic_irq_ready_i;
  end

  // offer_q is untouched until the next SELECT, so it still holds the claimed id.
  always_comb begin
    clic_irq_valid_o = (state_q == OFFER);
    clic_kill_req_o  = (state_q == KILL);
    clic_irq_id_o    = offer_q.id;
    clic_irq_level_o = offer_q.level;
    clic_irq_priv_o  = offer_q.priv;
    clic_irq_shv_o   = offer_q.shv;
    claim_valid_o    = claim_valid_q;
    claim_id_o       = offer_q.id;
  end

endmodule

// File: tb/tb_clic_irq_sequencer.sv
// Scoreboard bench for clic_irq_sequencer: stimulus pushes expected offer /
// claim / kill events computed from a source-array reference model.
module tb_clic_irq_sequencer;

  localparam int NumIrq     = 64;
  localparam int IdWidth    = 6;
  localparam int LevelWidth = 8;

  logic                              clk;
  logic                              rst_n;
  logic                              en;
  logic [LevelWidth-1:0]             thr;
  logic [NumIrq-1:0]                 pend;
  logic [NumIrq-1:0][LevelWidth-1:0] lvl;
  logic [NumIrq-1:0][1:0]            priv;
  logic [NumIrq-1:0]                 shv;
  logic                              ready;
  logic                              ack;
  logic                              valid;
  logic [IdWidth-1:0]                o_id;
  logic [LevelWidth-1:0]             o_level;
  logic [1:0]                        o_priv;
  logic                              o_shv;
  logic                              kill;
  logic                              claim;
  logic [IdWidth-1:0]                claim_id;

  clic_irq_sequencer #(
    .NumIrq    (NumIrq),
    .IdWidth   (IdWidth),
    .LevelWidth(LevelWidth)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (en),
    .threshold_i     (thr),
    .irq_pending_i   (pend),
    .irq_level_i     (lvl),
    .irq_priv_i      (priv),
    .irq_shv_i       (shv),
    .clic_irq_valid_o(valid),
    .clic_irq_id_o   (o_id),
    .clic_irq_level_o(o_level),
    .clic_irq_priv_o (o_priv),
    .clic_irq_shv_o  (o_shv),
    .clic_irq_ready_i(ready),
    .clic_kill_req_o (kill),
    .clic_kill_ack_i (ack),
    .claim_valid_o   (claim),
    .claim_id_o      (claim_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;  // 0 offer, 1 claim, 2 kill
    int id;
    int level;
    int pv;
    int sh;
  } ev_t;
  ev_t exp_q[$];

  // ---------------- reference model ----------------
  function automatic bit ref_elig(int i);
    return pend[i] && (lvl[i] != 0) && (int'(lvl[i]) > int'(thr));
  endfunction

  function automatic int ref_winner();
    int best = -1;
    for (int i = 0; i < NumIrq; i++) begin
      if (ref_elig(i) && (best < 0 || int'(lvl[i]) > int'(lvl[best]))) best = i;
    end
    return best;
  endfunction

  function automatic bit ref_kill(int oid, int olvl);
    if (!en || !ref_elig(oid)) return 1'b1;
    for (int k = 0; k < NumIrq; k++) begin
      if (k != oid && ref_elig(k) && int'(lvl[k]) > olvl) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic string kname(int k);
    case (k)
      0: return "offer";
      1: return "claim";
      default: return "kill";
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic                  p_valid, p_kill, p_claim;
  logic [IdWidth-1:0]    h_id;
  logic [LevelWidth-1:0] h_level;
  logic [1:0]            h_priv;
  logic                  h_shv;

  task automatic check_ev(input int kind, input int id, input int level, input int pv, input int sh);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s id=%0d, required no event", kname(kind), id);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != 2 && e.id != id) ||
          (kind == 0 && (e.level != level || e.pv != pv || e.sh != sh))) begin
        errors++;
        $display("FAIL %s_event: got %s id=%0d lvl=%0d priv=%0d shv=%0d, required %s id=%0d lvl=%0d priv=%0d shv=%0d",
                 kname(kind), kname(kind), id, level, pv, sh,
                 kname(e.kind), e.id, e.level, e.pv, e.sh);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
      p_kill  = 1'b0;
      p_claim = 1'b0;
    end else begin
      if (claim && !p_claim) check_ev(1, int'(claim_id), 0, 0, 0);
      if (kill && !p_kill) check_ev(2, 0, 0, 0, 0);
      if (valid && !p_valid) begin
        check_ev(0, int'(o_id), int'(o_level), int'(o_priv), int'(o_shv));
        h_id = o_id; h_level = o_level; h_priv = o_priv; h_shv = o_shv;
      end else if (valid && p_valid) begin
        checks++;
        if ({o_id, o_level, o_priv, o_shv} != {h_id, h_level, h_priv, h_shv}) begin
          errors++;
          $display("FAIL offer_stable: got id=%0d lvl=%0d, required id=%0d lvl=%0d", o_id, o_level, h_id, h_level);
        end
      end
      p_valid = valid;
      p_kill  = kill;
      p_claim = claim;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clear_srcs();
    pend = '0; lvl = '0; priv = '0; shv = '0;
  endtask

  task automatic set_src(input int i, input int l, input int p, input int s);
    pend[i] = 1'b1;
    lvl[i]  = LevelWidth'(l);
    priv[i] = 2'(p);
    shv[i]  = 1'(s);
  endtask

  task automatic push_offer(input int w);
    exp_q.push_back('{0, w, int'(lvl[w]), int'(priv[w]), int'(shv[w])});
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (valid || o_id != 0 || o_level != 0 || o_priv != 0 || o_shv || kill || claim || claim_id != 0) begin
      errors++;
      $display("FAIL %s: got valid=%0d id=%0d lvl=%0d priv=%0d shv=%0d kill=%0d claim=%0d cid=%0d, required all 0",
               nm, valid, o_id, o_level, o_priv, o_shv, kill, claim, claim_id);
    end
  endtask

  task automatic wait_valid(input int exp_lat, input string nm);
    int n = 0;
    while (!valid && n < 20) begin
      cyc(1);
      n++;
    end
    checks++;
    if (!valid || n != exp_lat) begin
      errors++;
      $display("FAIL %s: got valid=%0d after %0d cycles, required valid=1 after %0d", nm, valid, n, exp_lat);
    end
  endtask

  task automatic accept(input int w, input string nm);
    exp_q.push_back('{1, w, 0, 0, 0});
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    pend[w] = 1'b0;
    checks++;
    if (valid) begin
      errors++;
      $display("FAIL %s_valid_drop: got valid=%0d, required 0", nm, valid);
    end
  endtask

  task automatic enter_kill(input string nm);
    int n = 0;
    exp_q.push_back('{2, 0, 0, 0, 0});
    while (!kill && n < 10) begin
      cyc(1);
      n++;
    end
    checks++;
    if (!kill || n != 1 || valid) begin
      errors++;
      $display("FAIL %s: got kill_req=%0d valid=%0d after %0d cycles, required kill_req=1 valid=0 after 1", nm, kill, valid, n);
    end
  endtask

  task automatic ack_kill(input string nm);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    checks++;
    if (kill || valid) begin
      errors++;
      $display("FAIL %s: got kill_req=%0d valid=%0d, required 0 0", nm, kill, valid);
    end
  endtask

  task automatic expect_quiet(input int n, input string nm);
    bit seen = 1'b0;
    repeat (n) begin
      cyc(1);
      if (valid || kill) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: got valid/kill activity, required none", nm);
    end
  endtask

  task automatic offer_next(output int w, input string nm);
    w = ref_winner();
    if (w < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no eligible source in model, required one", nm);
    end else begin
      push_offer(w);
      wait_valid(2, nm);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int olvl;
    int act;
    rst_n = 1'b0;
    en = 1'b1; thr = '0; ready = 1'b0; ack = 1'b0;
    clear_srcs();
    #1 check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // single source, plus a stray kill_ack during OFFER that must be ignored
    set_src(5, 3, 3, 1);
    offer_next(w, "single_latency");
    ack = 1'b1; cyc(1); ack = 1'b0;
    checks++;
    if (!valid || kill) begin
      errors++;
      $display("FAIL stray_ack: got valid=%0d kill=%0d, required 1 0", valid, kill);
    end
    accept(w, "single_claim");

    // tie and priority ordering, back-to-back claims
    set_src(9, 7, 1, 0); set_src(4, 7, 3, 1); set_src(12, 6, 0, 1);
    for (int k = 0; k < 3; k++) begin
      offer_next(w, "tie_offer");
      if (w >= 0) accept(w, "tie_claim");
    end

    // preemption by a higher level while held; ready during KILL is ignored
    set_src(2, 3, 1, 0);
    offer_next(w, "preempt_first");
    set_src(7, 10, 3, 1);
    enter_kill("preempt_kill");
    ready = 1'b1; cyc(2); ready = 1'b0; cyc(1);
    ack_kill("preempt_ack");
    for (int k = 0; k < 2; k++) begin
      offer_next(w, "preempt_reoffer");
      if (w >= 0) accept(w, "preempt_claim");
    end

    // ready wins over a same-cycle preemption
    set_src(2, 3, 1, 0);
    offer_next(w, "race_offer");
    exp_q.push_back('{1, w, 0, 0, 0});
    ready = 1'b1;
    set_src(7, 10, 3, 1);
    cyc(1);
    ready = 1'b0;
    pend[w] = 1'b0;
    offer_next(w, "race_next");
    if (w >= 0) accept(w, "race_claim");

    // threshold boundary and enable drop
    thr = 8'd5;
    set_src(3, 5, 0, 0);
    expect_quiet(5, "thr_equal_quiet");
    thr = 8'd4;
    offer_next(w, "thr_offer");
    en = 1'b0;
    enter_kill("disable_kill");
    ack_kill("disable_ack");
    expect_quiet(4, "disabled_quiet");
    en = 1'b1;
    offer_next(w, "enable_reoffer");
    if (w >= 0) accept(w, "enable_claim");
    thr = '0;

    // asynchronous reset while in KILL
    set_src(11, 9, 2, 1);
    offer_next(w, "rst_offer");
    en = 1'b0;
    enter_kill("rst_kill");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    offer_next(w, "rst_reoffer");
    if (w >= 0) accept(w, "rst_claim");

    // randomized phase
    for (int it = 0; it < 40; it++) begin
      clear_srcs();
      thr = LevelWidth'($urandom_range(0, 6));
      for (int i = 0; i < NumIrq; i++) begin
        if ($urandom_range(0, 5) == 0)
          set_src(i, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      end
      for (int step = 0; step < 80; step++) begin
        w = ref_winner();
        if (w < 0) begin
          expect_quiet(4, "rand_quiet");
          break;
        end
        olvl = int'(lvl[w]);
        push_offer(w);
        wait_valid(2, "rand_latency");
        cyc($urandom_range(0, 3));
        act = $urandom_range(0, 3);
        if (act == 0)
          set_src($urandom_range(0, NumIrq - 1), $urandom_range(1, 15), $urandom_range(0, 3), $urandom_range(0, 1));
        else if (act == 1)
          thr = lvl[w];
        if (ref_kill(w, olvl)) begin
          enter_kill("rand_kill");
          cyc($urandom_range(0, 2));
          ack_kill("rand_ack");
        end else begin
          accept(w, "rand_claim");
        end
      end
    end

    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected events, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
